// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction memory addressing and
// the IF/ID pipeline register, with stall, flush and branch redirect.
// Optional fetch counter enabled by defining FETCH_PERF_CNT_EN; when the
// macro is undefined the counter is absent and fetch_count reads zero.
module fetch_stage #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         flush,
   input  logic         pcsrc,
   input  logic [N-1:0] branch_target,
   output logic [5:0]   imem_addr,
   input  logic [31:0]  imem_q,
   output logic [N-1:0] pc_out,
   output logic [N-1:0] if_pc,
   output logic [31:0]  if_instr,
   output logic         if_valid,
   output logic [31:0]  fetch_count
);

   logic [N-1:0] r_pc;
   logic [N-1:0] r_if_pc;
   logic [31:0]  r_if_instr;
   logic         r_if_valid;
   logic [N-1:0] w_pc_next;
   logic [N-1:0] w_target;
   logic         w_ifid_load;

   // Redirect target is word aligned; the low two bits are masked off.
   assign w_target    = branch_target & ~N'(3);
   assign w_ifid_load = !flush && !stall;

   // Next-PC selection: redirect beats stall, otherwise sequential (+4, wraps).
   always_comb begin
      w_pc_next = r_pc + N'(4);
      if (pcsrc) begin
         w_pc_next = w_target;
      end else if (stall) begin
         w_pc_next = r_pc;
      end
   end

   // PC register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= '0;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   // IF/ID register: flush inserts a bubble, stall holds, otherwise load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_if_pc    <= '0;
         r_if_instr <= '0;
         r_if_valid <= 1'b0;
      end else if (flush) begin
         r_if_pc    <= '0;
         r_if_instr <= '0;
         r_if_valid <= 1'b0;
      end else if (!stall) begin
         r_if_pc    <= r_pc;
         r_if_instr <= imem_q;
         r_if_valid <= 1'b1;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_count;

   // Saturating count of valid IF/ID loads.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_count <= '0;
      end else if (w_ifid_load && (r_fetch_count != '1)) begin
         r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   assign fetch_count = r_fetch_count;
`else
   assign fetch_count = '0;
`endif

   assign imem_addr = r_pc[7:2];
   assign pc_out    = r_pc;
   assign if_pc     = r_if_pc;
   assign if_instr  = r_if_instr;
   assign if_valid  = r_if_valid;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
- REQ-001: Parameter N, default 64: width of the PC, the branch target and the IF/ID PC field.
- REQ-002: clk  input  1  single clock; all state changes on its rising edge.
- REQ-003: reset  input  1  asynchronous, active-low reset.
- REQ-004: stall  input  1  hazard hold; when high, PC and IF/ID hold their values.
- REQ-005: flush  input  1  squash the IF/ID contents (bubble insert).
- REQ-006: pcsrc  input  1  branch redirect request.
- REQ-007: branch_target  input  N  redirect PC; bits [1:0] ignored.
- REQ-008: imem_addr  output  6  word address to instruction memory, equal to pc[7:2].
- REQ-009: imem_q  input  32  instruction word returned combinationally by instruction memory.
- REQ-010: pc_out  output  N  current fetch PC.
- REQ-011: if_pc  output  N  IF/ID register PC field.
- REQ-012: if_instr  output  32  IF/ID register instruction field.
- REQ-013: if_valid  output  1  IF/ID register valid flag.
- REQ-014: fetch_count  output  32  count of valid instructions loaded into IF/ID (see Configuration).

Function
- REQ-015: imem_addr is combinational from pc[7:2]; PC bits above 7 are ignored, so fetch wraps every 64 words.
- REQ-016: On each rising edge, the PC updates in this priority order:
  - pcsrc=1: PC loads {branch_target[N-1:2],2'b00}; stall is ignored.
  - stall=1: PC holds.
  - otherwise: PC loads PC+4, modulo 2^N (all-ones-minus-3 wraps to 0).
- REQ-017: On each rising edge, the IF/ID register updates in this priority order:
  - flush=1: if_instr=32'h00000000 (NOP), if_pc=0, if_valid=0.
  - stall=1: IF/ID holds.
  - otherwise: if_pc=PC, if_instr=imem_q, if_valid=1.
- REQ-018: The PC to IF/ID latency is one cycle; an instruction at PC P appears on if_instr the cycle after PC=P with no stall.
- REQ-019: When pcsrc=1 and flush=1 on the same edge, the next PC is the target and IF/ID holds a bubble.
  - The target instruction appears in IF/ID one cycle later.
- REQ-020: When stall=1 and flush=1 on the same edge, IF/ID becomes a bubble and the PC holds.
- REQ-021: pcsrc=1 with flush=0 is legal; the sequential instruction already fetched is still loaded into IF/ID (no implicit squash).
- REQ-022: stall held for K cycles freezes pc_out and all IF/ID outputs for exactly K cycles with no instruction lost or duplicated.

Reset
- REQ-023: While reset=0, asynchronously force PC=0, if_pc=0, if_instr=32'h00000000, if_valid=0 and fetch_count=0.
- REQ-024: Reset asserted mid-stall or mid-redirect discards the pending state.
- REQ-025: Reset release is synchronous to the next rising edge.
  - The first edge after release loads IF/ID with PC 0 and imem_q of word 0, and sets PC=4.

Configuration
- REQ-026: Macro FETCH_PERF_CNT_EN controls the fetch counter.
- REQ-027: When FETCH_PERF_CNT_EN is defined, fetch_count increments by 1 on each edge where IF/ID loads with if_valid=1.
  - The counter does not increment on stall or flush edges.
  - It saturates at 32'hFFFFFFFF.
- REQ-028: When FETCH_PERF_CNT_EN is undefined, no counter register exists and fetch_count is tied to 32'h0.

Verification
- REQ-029: Reset release with memory word0=32'h91003c0a and word1=32'haa14018b:
  - edge 1 -> if_pc=0, if_instr=32'h91003c0a, if_valid=1, pc_out=4;
  - edge 2 -> if_pc=4, if_instr=32'haa14018b.
- REQ-030: stall=1 for 3 cycles at pc_out=8:
  - pc_out stays 8 and IF/ID holds PC 4 for 3 cycles;
  - the next edge loads if_pc=8.
- REQ-031: pcsrc=1, flush=1, branch_target=0x1E at pc_out=0x20 -> next pc_out=0x1C and IF/ID is a bubble (valid=0, instr=0); the following edge gives if_pc=0x1C.
- REQ-032: PC=0xFC without stall -> the next imem_addr is 0 and pc_out=0x100 (address wrap).
- REQ-033: stall=1 and flush=1 together -> if_valid=0 and pc_out unchanged; asserting reset=0 mid-cycle immediately clears all outputs to 0.
- REQ-034: Counter checks:
  - with FETCH_PERF_CNT_EN, 10 free-running edges plus 2 stall edges and 1 flush edge -> fetch_count=10;
  - without the macro, fetch_count=0 throughout.
